tone_generator: RTL and testbench
=================================

TONE_GENERATOR -- requirements
Module: tone_generator

Interface
REQ-001 Parameter: NOTE_CYCLES, default 6250000, clocks a note plays before auto-stop (used only with TONE_GEN_DURATION_EN).
REQ-002 Port: clk  input  1  system clock; all logic is on its rising edge.
REQ-003 Port: reset  input  1  synchronous active-high reset.
REQ-004 Port: note_load  input  1  one-cycle strobe; captures octave and note and starts playing.
REQ-005 Port: octave  input  3  octave index, the quotient of the upstream divide-by-12 stage; 0 is lowest, 5 is highest valid.
REQ-006 Port: note  input  4  semitone index within the octave, the remainder of the upstream divide-by-12 stage; 0..11 are valid.
REQ-007 Port: stop  input  1  one-cycle strobe; silences output and returns to IDLE.
REQ-008 Port: speaker  output  1  square-wave tone output, registered.
REQ-009 Port: busy  output  1  high while state is PLAY, registered.
REQ-010 Port: done  output  1  one-cycle pulse when a note ends by auto-stop, registered.

Function
REQ-011 The FSM SHALL have two states: IDLE and PLAY.
REQ-012 In IDLE, a note_load SHALL register octave and note, load the counters, and enter PLAY on the next clock with speaker=0.
REQ-013 The note divider SHALL be a 9-bit constant table indexed by the latched note: 511,482,455,430,405,383,361,341,322,303,286,270 for notes 0..11.
REQ-014 The octave reload value SHALL be 8'd255 >> latched octave.
REQ-015 In PLAY, when cnt_note is nonzero it SHALL decrement; at zero it SHALL reload from the table and step the octave counter.
REQ-016 Octave step: when cnt_oct is nonzero it SHALL decrement; at zero it SHALL reload and toggle speaker.
REQ-017 The speaker half-period SHALL therefore be (DIV[note]+1)*((255>>octave)+1) clocks exactly.
REQ-018 A note value of 12..15 or an octave value of 6..7 SHALL still enter PLAY, with speaker held at 0 (silent rest).
REQ-019 A note_load in PLAY SHALL restart the note: re-latch the inputs, reload both counters, force speaker=0, and remain in PLAY.
REQ-020 A stop SHALL enter IDLE and force speaker=0 on the next clock; a stop in IDLE SHALL have no effect.
REQ-021 If stop and note_load are asserted in the same cycle, stop SHALL win and the load SHALL be discarded.
REQ-022 In IDLE, speaker SHALL be 0 and the counters SHALL hold.
REQ-023 busy SHALL be 1 exactly when the state is PLAY.

Reset
REQ-024 Reset SHALL force state=IDLE, speaker=0, busy=0, done=0, all counters=0 and latched octave and note=0.
REQ-025 Reset mid-PLAY SHALL silence the output on the next clock.
REQ-026 Reset SHALL take priority over stop and note_load.

Configuration
REQ-027 With TONE_GEN_DURATION_EN defined, a duration counter SHALL be included and SHALL behave as follows:
- It is cleared on every accepted note_load.
- It increments each PLAY cycle.
- On reaching NOTE_CYCLES-1, the block enters IDLE, forces speaker=0 and pulses done for one cycle.
- A stop SHALL end the note without pulsing done.
REQ-028 Without TONE_GEN_DURATION_EN, no duration counter SHALL exist, done SHALL be constant 0, and a note SHALL play until stop, reset or a new note_load.

Verification
REQ-029 Test: reset, then note_load with octave=5, note=0 -> busy=1, and speaker toggles every 4096 clocks.
REQ-030 Test: note_load with octave=0, note=11 -> speaker half-period is 69376 clocks.
REQ-031 Test: note_load with octave=2, note=13 -> busy=1, and speaker stays 0 for 10000 clocks.
REQ-032 Test: during PLAY, assert stop and note_load in the same cycle -> the next clock has busy=0, speaker=0, and no new note starts.
REQ-033 Test: with TONE_GEN_DURATION_EN and NOTE_CYCLES=100, note_load with octave=5, note=0 -> at 100 clocks, done pulses once, busy=0 and speaker=0.
REQ-034 Test: reset asserted mid-PLAY while speaker=1 -> the next clock has speaker=0, busy=0 and done=0.

Source files
------------

// File: rtl/tone_generator.sv
// -----------------------------------------------------------------------------
// tone_generator
//
// Square-wave tone generator driven by an (octave, note) pair coming from an
// upstream divide-by-12 stage. A 9-bit note divider counts down the semitone
// period. Each time it wraps it steps an 8-bit octave divider. Each time the
// octave divider wraps, the speaker output toggles. The resulting speaker
// half-period is (DIV[note]+1) * ((255 >> octave) + 1) clocks.
//
// Optional feature (macro TONE_GEN_DURATION_EN):
//   When defined, a duration counter ends each note after NOTE_CYCLES clocks
//   of PLAY. At that point the block returns to IDLE and pulses done.
//   When undefined, done is tied to 0 and a note plays until stop, reset or
//   a new note_load.
//
// Parameters:
//   NOTE_CYCLES  clocks a note plays before auto-stop (duration build only)
//
// Ports:
//   clk        in   system clock; all logic is on its rising edge
//   reset      in   synchronous active-high reset
//   note_load  in   one-cycle strobe: latch octave/note and start playing
//   octave     in   [2:0] octave index (0..5 valid, 6..7 play as a rest)
//   note       in   [3:0] semitone index (0..11 valid, 12..15 play as a rest)
//   stop       in   one-cycle strobe: silence and return to IDLE
//   speaker    out  registered square-wave output
//   busy       out  registered, high while in PLAY
//   done       out  registered one-cycle pulse on auto-stop (0 without macro)
// -----------------------------------------------------------------------------
module tone_generator #(
    parameter int NOTE_CYCLES = 6250000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       note_load,
    input  logic [2:0] octave,
    input  logic [3:0] note,
    input  logic       stop,
    output logic       speaker,
    output logic       busy,
    output logic       done
);

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

    state_t       state_reg,    state_next;
    logic [2:0]   oct_lat_reg,  oct_lat_next;
    logic [3:0]   note_lat_reg, note_lat_next;
    logic [8:0]   cnt_note_reg, cnt_note_next;
    logic [7:0]   cnt_oct_reg,  cnt_oct_next;
    logic         speaker_reg,  speaker_next;
    logic         busy_reg,     busy_next;

`ifdef TONE_GEN_DURATION_EN
    localparam logic [31:0] DUR_LAST = 32'(NOTE_CYCLES - 1);
    logic [31:0]  dur_cnt_reg,  dur_cnt_next;
    logic         done_reg,     done_next;
`endif

    // Semitone divider table. Indices 12..15 are rests and never toggle the
    // speaker, so the value returned for them only keeps the counter busy.
    function automatic logic [8:0] note_div(input logic [3:0] n);
        logic [8:0] d;
        case (n)
            4'd0:    d = 9'd511;
            4'd1:    d = 9'd482;
            4'd2:    d = 9'd455;
            4'd3:    d = 9'd430;
            4'd4:    d = 9'd405;
            4'd5:    d = 9'd383;
            4'd6:    d = 9'd361;
            4'd7:    d = 9'd341;
            4'd8:    d = 9'd322;
            4'd9:    d = 9'd303;
            4'd10:   d = 9'd286;
            4'd11:   d = 9'd270;
            default: d = 9'd0;
        endcase
        return d;
    endfunction

    function automatic logic [7:0] oct_div(input logic [2:0] o);
        return 8'd255 >> o;
    endfunction

    // A latched pair outside the valid range plays as a silent rest.
    logic lat_valid;
    assign lat_valid = (note_lat_reg < 4'd12) && (oct_lat_reg < 3'd6);

    // ------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        oct_lat_next  = oct_lat_reg;
        note_lat_next = note_lat_reg;
        cnt_note_next = cnt_note_reg;
        cnt_oct_next  = cnt_oct_reg;
        speaker_next  = speaker_reg;
`ifdef TONE_GEN_DURATION_EN
        dur_cnt_next  = dur_cnt_reg;
        done_next     = 1'b0;
`endif

        case (state_reg)
            IDLE: begin
                speaker_next = 1'b0;
                // stop has no effect in IDLE, but it still cancels a load
                // that arrives in the same cycle.
                if (note_load && !stop) begin
                    state_next    = PLAY;
                    oct_lat_next  = octave;
                    note_lat_next = note;
                    cnt_note_next = note_div(note);
                    cnt_oct_next  = oct_div(octave);
`ifdef TONE_GEN_DURATION_EN
                    dur_cnt_next  = '0;
`endif
                end
            end

            PLAY: begin
                if (stop) begin
                    state_next   = IDLE;
                    speaker_next = 1'b0;
                end else if (note_load) begin
                    // Restart: re-latch and start the tone from phase zero.
                    oct_lat_next  = octave;
                    note_lat_next = note;
                    cnt_note_next = note_div(note);
                    cnt_oct_next  = oct_div(octave);
                    speaker_next  = 1'b0;
`ifdef TONE_GEN_DURATION_EN
                    dur_cnt_next  = '0;
`endif
                end else begin
                    if (cnt_note_reg != 9'd0) begin
                        cnt_note_next = cnt_note_reg - 9'd1;
                    end else begin
                        cnt_note_next = note_div(note_lat_reg);
                        if (cnt_oct_reg != 8'd0) begin
                            cnt_oct_next = cnt_oct_reg - 8'd1;
                        end else begin
                            cnt_oct_next = oct_div(oct_lat_reg);
                            if (lat_valid) begin
                                speaker_next = ~speaker_reg;
                            end
                        end
                    end
`ifdef TONE_GEN_DURATION_EN
                    if (dur_cnt_reg == DUR_LAST) begin
                        state_next   = IDLE;
                        speaker_next = 1'b0;
                        done_next    = 1'b1;
                    end else begin
                        dur_cnt_next = dur_cnt_reg + 32'd1;
                    end
`endif
                end
            end

            default: begin
                state_next   = IDLE;
                speaker_next = 1'b0;
            end
        endcase

        busy_next = (state_next == PLAY);
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            oct_lat_reg  <= '0;
            note_lat_reg <= '0;
            cnt_note_reg <= '0;
            cnt_oct_reg  <= '0;
            speaker_reg  <= 1'b0;
            busy_reg     <= 1'b0;
`ifdef TONE_GEN_DURATION_EN
            dur_cnt_reg  <= '0;
            done_reg     <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            oct_lat_reg  <= oct_lat_next;
            note_lat_reg <= note_lat_next;
            cnt_note_reg <= cnt_note_next;
            cnt_oct_reg  <= cnt_oct_next;
            speaker_reg  <= speaker_next;
            busy_reg     <= busy_next;
`ifdef TONE_GEN_DURATION_EN
            dur_cnt_reg  <= dur_cnt_next;
            done_reg     <= done_next;
`endif
        end
    end

    assign speaker = speaker_reg;
    assign busy    = busy_reg;

`ifdef TONE_GEN_DURATION_EN
    assign done = done_reg;
`else
    assign done = 1'b0;
`endif

endmodule

// File: tb/tb_tone_generator.sv
// -----------------------------------------------------------------------------
// tb_tone_generator
//
// Directed bench for tone_generator. Inputs change 1 ns after a rising edge
// and outputs are sampled at that same point, so every check sees the
// registered result of the preceding edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tone_generator;

    logic       clk;
    logic       reset;
    logic       note_load;
    logic [2:0] octave;
    logic [3:0] note;
    logic       stop;
    logic       speaker;
    logic       busy;
    logic       done;

    int n_compared;
    int n_mismatched;

    tone_generator #(
        .NOTE_CYCLES(100)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .note_load (note_load),
        .octave    (octave),
        .note      (note),
        .stop      (stop),
        .speaker   (speaker),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        n_compared++;
        assert (observed === expected)
        else begin
            n_mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
        $display("check %-24s observed=%0d expected=%0d", tag, observed, expected);
    endtask

    // One-cycle note_load with the given pair.
    task automatic load_note(input logic [2:0] o, input logic [3:0] n);
        octave    = o;
        note      = n;
        note_load = 1'b1;
        tick();
        note_load = 1'b0;
    endtask

    initial begin
        int hi_seen;
        n_compared   = 0;
        n_mismatched = 0;
        reset     = 1'b1;
        note_load = 1'b0;
        stop      = 1'b0;
        octave    = 3'd0;
        note      = 4'd0;
        ticks(2);
        check("reset_speaker", 32'(speaker), 0);
        check("reset_busy",    32'(busy),    0);
        check("reset_done",    32'(done),    0);
        reset = 1'b0;
        tick();
        check("idle_busy", 32'(busy), 0);

`ifdef TONE_GEN_DURATION_EN
        // Auto-stop after NOTE_CYCLES=100 clocks of PLAY.
        load_note(3'd5, 4'd0);
        check("dur_busy_start", 32'(busy), 1);
        ticks(99);
        check("dur_done_early", 32'(done), 0);
        check("dur_busy_early", 32'(busy), 1);
        tick();
        check("dur_done_pulse", 32'(done),    1);
        check("dur_busy_end",   32'(busy),    0);
        check("dur_spk_end",    32'(speaker), 0);
        tick();
        check("dur_done_once",  32'(done),    0);

        // stop ends the note without a done pulse.
        load_note(3'd5, 4'd0);
        ticks(10);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("dur_stop_busy", 32'(busy), 0);
        check("dur_stop_done", 32'(done), 0);
        hi_seen = 0;
        for (int i = 0; i < 120; i++) begin
            tick();
            if (done) hi_seen = 1;
        end
        check("dur_stop_no_done", hi_seen, 0);
`else
        // octave 5, note 0: half-period (511+1)*(7+1) = 4096.
        load_note(3'd5, 4'd0);
        check("o5n0_busy",    32'(busy),    1);
        check("o5n0_spk0",    32'(speaker), 0);
        ticks(4095);
        check("o5n0_pre_hi",  32'(speaker), 0);
        tick();
        check("o5n0_hi",      32'(speaker), 1);
        ticks(4095);
        check("o5n0_pre_lo",  32'(speaker), 1);
        tick();
        check("o5n0_lo",      32'(speaker), 0);
        check("o5n0_done",    32'(done),    0);

        // octave 0, note 11: half-period (270+1)*(255+1) = 69376.
        load_note(3'd0, 4'd11);
        check("o0n11_spk0",   32'(speaker), 0);
        ticks(69375);
        check("o0n11_pre_hi", 32'(speaker), 0);
        tick();
        check("o0n11_hi",     32'(speaker), 1);

        // Reset while speaker is high.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_mid_spk",  32'(speaker), 0);
        check("rst_mid_busy", 32'(busy),    0);
        check("rst_mid_done", 32'(done),    0);

        // Out-of-range note: plays as a silent rest.
        load_note(3'd2, 4'd13);
        check("rest_busy", 32'(busy), 1);
        hi_seen = 0;
        for (int i = 0; i < 10000; i++) begin
            tick();
            if (speaker !== 1'b0) hi_seen = 1;
        end
        check("rest_silent",   hi_seen,     0);
        check("rest_busy_end", 32'(busy),   1);

        // Restart during PLAY: octave 5, note 11 half-period (270+1)*8 = 2168.
        load_note(3'd5, 4'd11);
        check("rs1_busy",   32'(busy),    1);
        ticks(2167);
        check("rs1_pre_hi", 32'(speaker), 0);
        tick();
        check("rs1_hi",     32'(speaker), 1);
        load_note(3'd5, 4'd11);
        check("rs2_spk0",   32'(speaker), 0);
        check("rs2_busy",   32'(busy),    1);
        ticks(2167);
        check("rs2_pre_hi", 32'(speaker), 0);
        tick();
        check("rs2_hi",     32'(speaker), 1);

        // stop and note_load together: stop wins, no new note.
        stop      = 1'b1;
        note_load = 1'b1;
        octave    = 3'd5;
        note      = 4'd0;
        tick();
        stop      = 1'b0;
        note_load = 1'b0;
        check("stopld_busy", 32'(busy),    0);
        check("stopld_spk",  32'(speaker), 0);
        ticks(3);
        check("stopld_idle", 32'(busy),    0);

        // stop in IDLE has no effect; a following load still starts.
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop_idle_busy", 32'(busy), 0);
        load_note(3'd5, 4'd0);
        check("after_idle_busy", 32'(busy), 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop_play_busy", 32'(busy),    0);
        check("stop_play_done", 32'(done),    0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
